ula_fl_mc: RTL and testbench



---
 rtl/ula_fl_mc.sv | 261 ++++++++++++++++++++++++++
 tb/tb_ula_fl_mc.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_fl_mc.sv
// ula_fl_mc -- multicycle floating-point ALU with valid/ready handshake.
//
// Number format: {sign, exponent (EXP bits, two's complement), mantissa (MAN bits,
// integer with explicit leading 1)}. Value = (-1)^s * m * 2^e. Zero is mantissa 0
// with exponent 100..0. Operands are assumed normalised (leading mantissa bit set)
// or zero. Rounding is truncation throughout.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  operand handshake; in_ready is high only when idle
//   op, in1, in2         opcode and operands, registered on accept
//   out_valid/out_ready  result handshake; out and flags hold while stalled
//   out                  result word
//   ovf, unf, dz, err_op exponent overflow, underflow, divide by zero, bad op
//
// Build option: define ULA_FL_MC_DIV_EN to include the iterative restoring
// divider (op 4). Without it, op 4 is reported through err_op like ops 12-15.
module ula_fl_mc #(
    parameter int EXP = 8,
    parameter int MAN = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           op,
    input  logic [MAN+EXP:0]     in1,
    input  logic [MAN+EXP:0]     in2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MAN+EXP:0]     out,
    output logic                 ovf,
    output logic                 unf,
    output logic                 dz,
    output logic                 err_op
);
    localparam int W  = MAN + EXP + 1;
    localparam int EW = EXP + 2;      // internal exponent width, signed

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] EXEC = 3'd1;
    localparam logic [2:0] NORM = 3'd2;
    localparam logic [2:0] DONE = 3'd3;
`ifdef ULA_FL_MC_DIV_EN
    localparam logic [2:0] DIVI = 3'd4;
    localparam int         CW   = $clog2(MAN);
    localparam logic [3:0] OP_DIV = 4'd4;
`endif

    localparam logic [3:0] OP_NOP = 4'd0,  OP_LOAD = 4'd1, OP_ADD = 4'd2, OP_MLT = 4'd3;
    localparam logic [3:0] OP_NEG = 4'd5,  OP_LES  = 4'd6, OP_EQU = 4'd7, OP_INV = 4'd8;
    localparam logic [3:0] OP_AND = 4'd9,  OP_GRE  = 4'd10, OP_OR = 4'd11;

    localparam logic signed [EW-1:0] EMAX = EW'((1 << (EXP - 1)) - 1);
    localparam logic signed [EW-1:0] EMIN = -EMAX;
    localparam logic [W-2:0]         SAT_MAG = {1'b0, {(EXP-1){1'b1}}, {MAN{1'b1}}};
    localparam logic [W-1:0]         ZERO_W  = {2'b01, {(W-2){1'b0}}};

    logic [2:0]           state;
    logic [3:0]           op_r;
    logic [W-1:0]         a_r, b_r, word_r;
    logic                 s_r, byp_r, err_r, dz_r;
    logic signed [EW-1:0] e_r;
    logic [MAN-1:0]       m_r;

    // operand fields
    logic                 s1, s2;
    logic signed [EW-1:0] e1, e2;
    logic [MAN-1:0]       m1, m2;

    assign s1 = a_r[W-1];
    assign s2 = b_r[W-1];
    assign e1 = {{2{a_r[W-2]}}, a_r[W-2:MAN]};
    assign e2 = {{2{b_r[W-2]}}, b_r[W-2:MAN]};
    assign m1 = a_r[MAN-1:0];
    assign m2 = b_r[MAN-1:0];

    // Alignment shared by ADD and the ordered compares: the mantissa with the
    // smaller exponent is shifted right, shift capped at MAN+1 (fully flushed).
    logic signed [EW-1:0]  ediff, emx;
    logic [EW-1:0]         adiff, sh;
    logic [MAN-1:0]        al1, al2;
    logic signed [MAN+1:0] v1, v2, sum;
    logic [MAN+1:0]        mag;
    logic [2*MAN-1:0]      prod;

    assign ediff = e1 - e2;
    assign adiff = ediff[EW-1] ? -ediff : ediff;
    assign sh    = (adiff > EW'(MAN + 1)) ? EW'(MAN + 1) : adiff;
    assign emx   = ediff[EW-1] ? e2 : e1;
    assign al1   = ediff[EW-1] ? (m1 >> sh) : m1;
    assign al2   = ediff[EW-1] ? m2 : (m2 >> sh);
    assign v1    = s1 ? -$signed({2'b00, al1}) : $signed({2'b00, al1});
    assign v2    = s2 ? -$signed({2'b00, al2}) : $signed({2'b00, al2});
    assign sum   = v1 + v2;
    assign mag   = sum[MAN+1] ? -sum : sum;
    assign prod  = {{MAN{1'b0}}, m1} * {{MAN{1'b0}}, m2};

    // low product bits and the halved-away sum bit are truncated by design
    logic unused_bits;
    assign unused_bits = ^{mag[MAN+1], mag[0], prod[MAN-1:0]};

    // compare/logic result word: constant 1 at bit MAN-1, result at bit 0
    logic         cmp_bit;
    logic [W-1:0] cmp_w;
    always_comb begin
        cmp_bit = 1'b0;
        case (op_r)
            OP_LES:  cmp_bit = (v1 < v2);
            OP_GRE:  cmp_bit = (v1 > v2);
            OP_EQU:  cmp_bit = (a_r == b_r);
            OP_INV:  cmp_bit = ~b_r[0];
            OP_AND:  cmp_bit = a_r[0] & b_r[0];
            OP_OR:   cmp_bit = a_r[0] | b_r[0];
            default: cmp_bit = 1'b0;
        endcase
        cmp_w          = '0;
        cmp_w[MAN-1]   = 1'b1;
        cmp_w[0]       = cmp_bit;
    end

    // leading-zero count of the raw mantissa; highest set bit wins
    logic [EW-1:0]        lz;
    logic [MAN-1:0]       mn;
    logic signed [EW-1:0] en;
    always_comb begin
        lz = '0;
        for (int i = 0; i < MAN; i++)
            if (m_r[i]) lz = EW'(MAN - 1 - i);
    end
    assign mn = m_r << lz;
    assign en = e_r - $signed(lz);

`ifdef ULA_FL_MC_DIV_EN
    // Restoring divider: partial remainder stays below 2*m2, so MAN+1 bits.
    logic [CW-1:0] cnt;
    logic [MAN:0]  rem, rem_nx;
    logic          q_bit;
    assign q_bit  = (rem >= {1'b0, m2});
    assign rem_nx = q_bit ? (rem - {1'b0, m2}) : rem;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            word_r <= '0;
            s_r    <= 1'b0;
            e_r    <= '0;
            m_r    <= '0;
            byp_r  <= 1'b0;
            err_r  <= 1'b0;
            dz_r   <= 1'b0;
            out    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            dz     <= 1'b0;
            err_op <= 1'b0;
`ifdef ULA_FL_MC_DIV_EN
            cnt    <= '0;
            rem    <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_r   <= op;
                    a_r    <= in1;
                    b_r    <= in2;
                    m_r    <= '0;
                    byp_r  <= 1'b0;
                    err_r  <= 1'b0;
                    dz_r   <= 1'b0;
                    ovf    <= 1'b0;
                    unf    <= 1'b0;
                    dz     <= 1'b0;
                    err_op <= 1'b0;
`ifdef ULA_FL_MC_DIV_EN
                    cnt    <= CW'(MAN - 1);
                    rem    <= {1'b0, in1[MAN-1:0]};
                    state  <= (op == OP_DIV) ? DIVI : EXEC;
`else
                    state  <= EXEC;
`endif
                end
                EXEC: begin
                    // default: bypass result word, fixed in NORM unchanged
                    state  <= NORM;
                    byp_r  <= 1'b1;
                    word_r <= '0;
                    s_r    <= 1'b0;
                    e_r    <= '0;
                    m_r    <= '0;
                    case (op_r)
                        OP_NOP:  word_r <= b_r;
                        OP_LOAD: word_r <= a_r;
                        OP_NEG:  word_r <= {~b_r[W-1], b_r[W-2:0]};
                        OP_ADD: begin
                            byp_r <= 1'b0;
                            s_r   <= sum[MAN+1];
                            e_r   <= emx + EW'(1);
                            m_r   <= mag[MAN:1];
                        end
                        OP_MLT: begin
                            byp_r <= 1'b0;
                            s_r   <= s1 ^ s2;
                            e_r   <= e1 + e2 + EW'(MAN);
                            m_r   <= (m1 == '0 || m2 == '0) ? '0 : prod[2*MAN-1:MAN];
                        end
                        OP_LES, OP_GRE, OP_EQU, OP_INV, OP_AND, OP_OR:
                            word_r <= cmp_w;
                        default: err_r <= 1'b1;
                    endcase
                end
`ifdef ULA_FL_MC_DIV_EN
                DIVI: begin
                    s_r <= s1 ^ s2;
                    e_r <= e1 - e2 - EW'(MAN - 1);
                    if (m2 == '0) begin
                        dz_r  <= 1'b1;
                        state <= NORM;
                    end else begin
                        // quotient bits enter at the LSB, MSB first
                        m_r <= {m_r[MAN-2:0], q_bit};
                        rem <= rem_nx << 1;
                        if (cnt == '0) state <= NORM;
                        else           cnt   <= cnt - CW'(1);
                    end
                end
`endif
                NORM: begin
                    state <= DONE;
                    if (byp_r) begin
                        out    <= word_r;
                        err_op <= err_r;
                    end else if (dz_r) begin
                        out <= {s_r, SAT_MAG};
                        dz  <= 1'b1;
                    end else if (m_r == '0) begin
                        out <= ZERO_W;
                    end else if (en > EMAX) begin
                        out <= {s_r, SAT_MAG};
                        ovf <= 1'b1;
                    end else if (en < EMIN) begin
                        out <= ZERO_W;
                        unf <= 1'b1;
                    end else begin
                        out <= {s_r, en[EXP-1:0], mn};
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_fl_mc.sv
// Self-checking bench for ula_fl_mc: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_ula_fl_mc;
    localparam int EXP = 8;
    localparam int MAN = 23;
    localparam int W   = MAN + EXP + 1;
    localparam logic [W-1:0] ZERO = 32'h4000_0000;

    logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] in1 = '0, in2 = '0;
    logic         in_ready, out_valid, ovf, unf, dz, err_op;
    logic [W-1:0] out;

    int n_chk = 0, n_err = 0;
    logic [W-1:0] obs_out;
    logic [3:0]   obs_fl;

    always #5 clk = ~clk;

    ula_fl_mc #(.EXP(EXP), .MAN(MAN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .ovf(ovf), .unf(unf), .dz(dz), .err_op(err_op)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pk(input logic s, input logic [7:0] e, input logic [22:0] m);
        return {s, e, m};
    endfunction

    // normalise a value s * m * 2^e into the result word; flags {ovf,unf,dz,err}
    function automatic void norm(input logic s, input int e_in, input longint m_in,
                                 output logic [W-1:0] r, output logic [3:0] fl);
        int e = e_in;
        longint m = m_in;
        fl = 4'b0000;
        if (m == 0) begin
            r = ZERO;
            return;
        end
        while (m < (64'sd1 <<< 22)) begin
            m = m * 2;
            e = e - 1;
        end
        if (e > 127) begin
            r = {s, 8'h7F, 23'h7FFFFF}; fl = 4'b1000;
        end else if (e < -127) begin
            r = ZERO; fl = 4'b0100;
        end else begin
            r = {s, 8'(e), 23'(m)};
        end
    endfunction

    function automatic void model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [3:0] fl, output int lat);
        logic   s1, s2;
        int     e1, e2, emx;
        longint m1, m2, x1, x2, v1, v2, t;
        s1 = a[31]; s2 = b[31];
        e1 = int'($signed(a[30:23])); e2 = int'($signed(b[30:23]));
        m1 = longint'(a[22:0]); m2 = longint'(b[22:0]);
        emx = (e1 > e2) ? e1 : e2;
        x1 = ((emx - e1) >= 24) ? 0 : (m1 >> (emx - e1));
        x2 = ((emx - e2) >= 24) ? 0 : (m2 >> (emx - e2));
        v1 = s1 ? -x1 : x1;
        v2 = s2 ? -x2 : x2;
        lat = 3; fl = 4'b0000; r = '0;
        case (o)
            4'd0: r = b;
            4'd1: r = a;
            4'd5: r = {~b[31], b[30:0]};
            4'd2: begin
                t = v1 + v2;
                norm(t < 0, emx + 1, ((t < 0) ? -t : t) / 2, r, fl);
            end
            4'd3: begin
                if (m1 == 0 || m2 == 0) r = ZERO;
                else norm(s1 ^ s2, e1 + e2 + 23, (m1 * m2) >> 23, r, fl);
            end
            4'd4: begin
`ifdef ULA_FL_MC_DIV_EN
                if (m2 == 0) begin
                    r = {s1 ^ s2, 8'h7F, 23'h7FFFFF}; fl = 4'b0010;
                end else begin
                    lat = 25;
                    norm(s1 ^ s2, e1 - e2 - 22, ((m1 <<< 22) / m2) % (64'sd1 <<< 23), r, fl);
                end
`else
                fl = 4'b0001;
`endif
            end
            4'd6:  begin r = 32'h0040_0000; r[0] = (v1 < v2); end
            4'd10: begin r = 32'h0040_0000; r[0] = (v1 > v2); end
            4'd7:  begin r = 32'h0040_0000; r[0] = (a == b); end
            4'd8:  begin r = 32'h0040_0000; r[0] = ~b[0]; end
            4'd9:  begin r = 32'h0040_0000; r[0] = a[0] & b[0]; end
            4'd11: begin r = 32'h0040_0000; r[0] = a[0] | b[0]; end
            default: fl = 4'b0001;
        endcase
    endfunction

    // issue one op, check latency/result/flags, optionally stall the consumer
    task automatic run(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, input string tag);
        logic [W-1:0] er;
        logic [3:0]   ef;
        int           el, n;
        logic         bad;
        model(o, a, b, er, ef, el);
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk({tag, " ready"}, 64'(in_ready), 64'd1);
            return;
        end
        in_valid = 1'b1; op = o; in1 = a; in2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        obs_out = out;
        obs_fl  = {ovf, unf, dz, err_op};
        chk({tag, " lat"}, 64'(n), 64'(el));
        chk({tag, " out"}, 64'(out), 64'(er));
        chk({tag, " flags"}, 64'({ovf, unf, dz, err_op}), 64'(ef));
        bad = 1'b0;
        if (hold > 0) begin
            // a competing request during the stall must be ignored
            in_valid = 1'b1; op = 4'd1; in1 = ~a; in2 = ~b;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (out !== er || {ovf, unf, dz, err_op} !== ef || !out_valid || in_ready)
                    bad = 1'b1;
            end
            chk({tag, " hold"}, 64'(bad), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " idle"}, 64'(in_ready), 64'd1);
    endtask

    function automatic logic [W-1:0] rnd();
        logic [7:0] e;
        if ($urandom_range(0, 7) == 0) return ZERO;
        if ($urandom_range(0, 1) == 0) e = 8'($urandom_range(0, 16)) - 8'd30;
        else                           e = 8'($urandom_range(0, 254)) - 8'd127;
        return {1'($urandom_range(0, 1)), e, 23'h400000 | 23'($urandom & 32'h3FFFFF)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] one, two, three, six, a, b;
        logic [3:0]   o;
        one   = pk(1'b0, 8'hEA, 23'h400000);
        two   = pk(1'b0, 8'hEB, 23'h400000);
        three = pk(1'b0, 8'hEB, 23'h600000);
        six   = pk(1'b0, 8'hEC, 23'h600000);

        // reset state
        #12;
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out", 64'(out), 64'd0);
        chk("rst flags", 64'({ovf, unf, dz, err_op}), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        run(4'd2, one, two, 0, "add 1+2");
        chk("add spec", 64'(obs_out), 64'(three));
        run(4'd3, two, three, 0, "mlt 2x3");
        chk("mlt spec", 64'(obs_out), 64'(six));
        run(4'd3, three, ZERO, 0, "mlt 3x0");
        chk("mlt0 spec", 64'(obs_out), 64'(ZERO));
        run(4'd4, six, two, 0, "div 6/2");
`ifdef ULA_FL_MC_DIV_EN
        chk("div spec", 64'(obs_out), 64'(three));
        run(4'd4, one, ZERO, 0, "div 1/0");
        chk("dz spec", 64'({obs_fl, obs_out}), 64'({4'b0010, 32'h3FFF_FFFF}));
`else
        chk("div spec", 64'({obs_fl, obs_out}), 64'({4'b0001, 32'h0}));
`endif
        run(4'd3, pk(1'b0, 8'h7F, 23'h400000), pk(1'b0, 8'h7F, 23'h400000), 0, "mlt ovf");
        chk("ovf spec", 64'({obs_fl, obs_out}), 64'({4'b1000, 32'h3FFF_FFFF}));
        run(4'd3, pk(1'b0, 8'h81, 23'h400000), pk(1'b0, 8'h81, 23'h400000), 0, "mlt unf");
        chk("unf spec", 64'({obs_fl, obs_out}), 64'({4'b0100, ZERO}));
        run(4'd6, one, two, 0, "les");
        chk("les spec", 64'(obs_out), 64'h0040_0001);
        run(4'd10, one, two, 0, "gre");
        chk("gre spec", 64'(obs_out), 64'h0040_0000);
        run(4'd13, one, two, 0, "op13");
        run(4'd2, two, three, 10, "backpressure");
        run(4'd5, three, six, 0, "neg after bp");

        // reset in the middle of a DIV
        @(negedge clk);
        in_valid = 1'b1; op = 4'd4; in1 = six; in2 = two;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst in_ready", 64'(in_ready), 64'd1);
        chk("midrst out", 64'({ovf, unf, dz, err_op, out}), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        run(4'd1, six, one, 0, "load after rst");

        for (int k = 0; k < 150; k++) begin
            o = 4'($urandom_range(0, 15));
            a = rnd();
            b = (o == 4'd7 && $urandom_range(0, 1) == 1) ? a : rnd();
            run(o, a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
